mdio_master: RTL and testbench
==============================

Name: mdio_master

Overview:
- Ethernet PHY management (MDIO/SMI) station controller.
- Consumes the divided clock produced by the pulse divider stage as MDC and runs IEEE 802.3 clause-22 read/write frames on it.
- Sits between the register/config logic (command side) and the PHY management pins.
- All logic runs in the clk domain. MDC edges are detected by sampling mdc_in.

Parameters:
- PREAMBLE_LEN, 32: number of preamble '1' slots, legal range 1..32.
- SYNC_STAGES, 2: synchroniser depth on mdio_i, minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- mdc_in  in  1  divided clock from the pulse divider; also drives the MDC pin externally; half-period ≥ 4 clk cycles
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_read  in  1  1 = read, 0 = write
- cmd_phy  in  5  PHY address
- cmd_reg  in  5  register address
- cmd_wdata  in  16  write data
- done  out  1  one-cycle pulse at frame end
- rd_data  out  16  read result, held until the next read completes
- busy  out  1  frame in progress
- mdio_o  out  1  pin output value
- mdio_oe  out  1  pin output enable (1 = drive)
- mdio_i  in  1  pin input, asynchronous
- ta_err  out  1  sticky turnaround error (feature only; tied 0 otherwise)

Behaviour:
- Reset state:
  - state = IDLE; mdio_oe = 0; mdio_o = 1; done = 0; busy = 0; rd_data = 0; ta_err = 0.
  - cmd_ready = 1 from the first cycle after reset release.
- Edge detection:
  - mdc_q holds mdc_in delayed one clk.
  - fall = mdc_q & ~mdc_in.
  - All slot actions occur on the clk edge where fall is true, so mdio_o/mdio_oe change 1 clk after mdc_in falls.
  - Rising edges are unused.
- Accept:
  - A command is accepted when cmd_valid & cmd_ready.
  - On acceptance, a 32-bit shift register loads {01, op, cmd_phy, cmd_reg, ta, cmd_wdata}.
  - op = 10 for read, 01 for write; ta = 10 for write (the ta field is ignored for read).
  - The slot counter clears and the state goes WAIT. busy rises the same cycle.
  - Commands presented while busy are not accepted (cmd_ready = 0) and are not lost: the requester holds them.
- States:
  - IDLE → WAIT (on accept).
  - WAIT → PRE at the first fall; that edge starts slot 0.
  - PRE: drives mdio_o = 1, mdio_oe = 1 for PREAMBLE_LEN slots.
  - FRAME: 14 slots, shifting out MSB first (ST, OP, PHYAD, REGAD).
  - TA: 2 slots.
    - Write: drive 1 then 0.
    - Read: mdio_oe = 0 for both slots and all following slots.
  - DATA: 16 slots.
    - Write: drive cmd_wdata MSB first.
    - Read: sample the synchronised mdio_i at each fall that ends a data slot, MSB first, into a shift register.
  - DONE: at the fall ending the last data slot (slot PREAMBLE_LEN+31):
    - mdio_oe = 0, mdio_o = 1;
    - for read, rd_data is updated with the full 16 bits;
    - done pulses 1 cycle, busy drops, state goes IDLE.
- Frame length: PREAMBLE_LEN + 32 slots. The counter is 7 bits.
- Consecutive commands: a command may be accepted in the cycle after done. Its slot 0 starts at the next fall, so there are no idle slots beyond that wait.
- A write leaves rd_data unchanged.
- Reset mid-frame: the state, oe, busy and counters return to reset values on the next clk edge. No done pulse, rd_data is cleared, and the PHY sees a truncated frame (legal, recovered by the next preamble).
- If mdc_in stops toggling, the block waits indefinitely. There is no timeout.

Optional Feature:
- Macro: MDIO_TA_CHECK_EN.
- Defined:
  - On a read, the synchronised mdio_i is sampled at the fall ending TA slot 2; it must be 0 (PHY driving).
  - If it is 1, ta_err sets and stays set until rst. The frame still completes and rd_data is still updated.
- Undefined: no check logic; ta_err is tied 0.

Decomposition:
- Package mdio_pkg holds:
  - state enum (IDLE, WAIT, PRE, FRAME, TA, DATA);
  - constants ST_BITS=2'b01, OP_READ=2'b10, OP_WRITE=2'b01, TA_WRITE=2'b10, FRAME_SLOTS=32.
- One sub-module: mdio_sync, the SYNC_STAGES-deep synchroniser for mdio_i.

Test Plan:
- Write phy=5'h01, reg=5'h00, wdata=16'h1140, divider ticks=8 → mdio_o across 64 slots equals 32×1, 0101, 00001, 00000, 10, 0001000101000000. mdio_oe=1 for slots 0–63 and 0 after. done pulses once, 1 clk after fall 64.
- Read phy=5'h03, reg=5'h02 with a PHY model returning 16'h0141 → mdio_oe drops at slot 46. rd_data=16'h0141 coincident with done.
- Back-to-back: write issued on the cycle after the previous done → slot 0 of the new frame starts at the next fall; cmd_ready=0 throughout the frame.
- Assert rst at slot 40 → mdio_oe=0, busy=0, cmd_ready=1 the next cycle, no done pulse. A following read completes normally.
- PREAMBLE_LEN=1 → the frame is 33 slots and ST starts at slot 1.
- With MDIO_TA_CHECK_EN defined, the PHY model leaves the line high during TA → ta_err=1 after the frame, done still pulses, and ta_err holds until rst.

Source files
------------

// File: rtl/mdio_pkg.sv
// mdio_pkg: shared types and constants for the MDIO (clause-22) station
// controller.
//   mdio_state_e : controller states
//   ST_BITS, OP_READ, OP_WRITE, TA_WRITE : fixed frame fields
//   FRAME_SLOTS  : MDC slots in a frame after the preamble
//   build_frame  : assembles the 32-bit word shifted out after the preamble
package mdio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        PRE,
        FRAME,
        TA,
        DATA
    } mdio_state_e;

    localparam logic [1:0] ST_BITS  = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] TA_WRITE = 2'b10;
    localparam int         FRAME_SLOTS = 32;

    // For a read, the TA and data fields are still loaded but never driven:
    // the pin is released from the first turnaround slot onward.
    function automatic logic [31:0] build_frame(
        input logic        is_read,
        input logic [4:0]  phy,
        input logic [4:0]  regad,
        input logic [15:0] wdata
    );
        return {ST_BITS, (is_read ? OP_READ : OP_WRITE), phy, regad, TA_WRITE, wdata};
    endfunction

endpackage

// File: rtl/mdio_sync.sv
// mdio_sync: multi-flop synchroniser bringing the asynchronous MDIO pin
// into the clk domain.
//   clk, rst : system clock, synchronous active-high reset
//   d        : asynchronous input (MDIO pin)
//   q        : synchronised output, SYNC_STAGES clk cycles of latency
// The chain resets to 1, the idle (pulled-up) level of the MDIO line.
module mdio_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/mdio_master.sv
// mdio_master: Ethernet PHY management (MDIO/SMI) station controller that
// runs IEEE 802.3 clause-22 read/write frames on an externally divided MDC.
//   clk, rst      : system clock, synchronous active-high reset
//   mdc_in        : divided clock (also the MDC pin); only its falling edges
//                   are used, detected by sampling in the clk domain
//   cmd_*         : command handshake (valid/ready), op, PHY/reg addr, data
//   done          : one-cycle pulse when a frame finishes
//   rd_data       : last read result, held until the next read completes
//   busy          : frame in progress
//   mdio_o/oe/i   : MDIO pin output value, output enable, async input
//   ta_err        : sticky turnaround error on reads
// Optional feature macro MDIO_TA_CHECK_EN: when defined, a read checks that
// the PHY pulls the line low in the second turnaround slot and sets ta_err
// otherwise; when undefined, ta_err is tied to 0.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int PREAMBLE_LEN = 32,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mdc_in,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_read,
    input  logic [4:0]  cmd_phy,
    input  logic [4:0]  cmd_reg,
    input  logic [15:0] cmd_wdata,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        busy,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i,
    output logic        ta_err
);

    // Slot numbers (slot 0 = first preamble slot) where each field begins.
    localparam logic [6:0] P_SLOTS    = 7'(PREAMBLE_LEN);
    localparam logic [6:0] TA_FIRST   = 7'(PREAMBLE_LEN + 14);
    localparam logic [6:0] DATA_FIRST = 7'(PREAMBLE_LEN + 16);
    localparam logic [6:0] LAST_SLOT  = 7'(PREAMBLE_LEN + FRAME_SLOTS - 1);

    mdio_state_e state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [31:0] sr_q, sr_d;
    logic        is_read_q, is_read_d;
    logic [14:0] rd_shift_q, rd_shift_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        mdio_o_q, mdio_o_d;
    logic        mdio_oe_q, mdio_oe_d;
    logic        done_q, done_d;
    logic        mdc_q;
    logic        fall;
    logic        mdio_s;
    logic [6:0]  cnt_inc;
    logic        shift_oe;

    mdio_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (mdio_i),
        .q  (mdio_s)
    );

    assign fall    = mdc_q & ~mdc_in;
    assign cnt_inc = cnt_q + 7'd1;
    // On reads the pin is released from the first turnaround slot onward.
    assign shift_oe = !(is_read_q && (cnt_inc >= TA_FIRST));

`ifdef MDIO_TA_CHECK_EN
    localparam logic [6:0] TA_LAST = 7'(PREAMBLE_LEN + 15);
    logic ta_err_q, ta_err_d;
`endif

    // Every slot action happens on the clk edge that sees an MDC fall; the
    // counter holds the number of the slot currently on the wire.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        is_read_d  = is_read_q;
        rd_shift_d = rd_shift_q;
        rd_data_d  = rd_data_q;
        mdio_o_d   = mdio_o_q;
        mdio_oe_d  = mdio_oe_q;
        done_d     = 1'b0;
`ifdef MDIO_TA_CHECK_EN
        ta_err_d   = ta_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    sr_d      = build_frame(cmd_read, cmd_phy, cmd_reg, cmd_wdata);
                    is_read_d = cmd_read;
                    cnt_d     = '0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (fall) begin
                    cnt_d     = '0;
                    mdio_o_d  = 1'b1;
                    mdio_oe_d = 1'b1;
                    state_d   = PRE;
                end
            end
            PRE: begin
                if (fall) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == P_SLOTS) begin
                        mdio_o_d = sr_q[31];
                        sr_d     = {sr_q[30:0], 1'b0};
                        state_d  = FRAME;
                    end else begin
                        mdio_o_d = 1'b1;
                    end
                end
            end
            FRAME, TA: begin
                if (fall) begin
                    cnt_d     = cnt_inc;
                    sr_d      = {sr_q[30:0], 1'b0};
                    mdio_oe_d = shift_oe;
                    mdio_o_d  = shift_oe ? sr_q[31] : 1'b1;
`ifdef MDIO_TA_CHECK_EN
                    // This fall ends the second turnaround slot, where the
                    // PHY must already be pulling the line low.
                    if ((state_q == TA) && is_read_q && (cnt_q == TA_LAST) && mdio_s) begin
                        ta_err_d = 1'b1;
                    end
`endif
                    if (cnt_inc == TA_FIRST) begin
                        state_d = TA;
                    end else if (cnt_inc == DATA_FIRST) begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (fall) begin
                    // Each fall in DATA ends one data slot: capture it.
                    if (is_read_q) begin
                        rd_shift_d = {rd_shift_q[13:0], mdio_s};
                    end
                    if (cnt_q == LAST_SLOT) begin
                        if (is_read_q) begin
                            rd_data_d = {rd_shift_q, mdio_s};
                        end
                        cnt_d     = '0;
                        mdio_o_d  = 1'b1;
                        mdio_oe_d = 1'b0;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        cnt_d     = cnt_inc;
                        sr_d      = {sr_q[30:0], 1'b0};
                        mdio_oe_d = shift_oe;
                        mdio_o_d  = shift_oe ? sr_q[31] : 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            is_read_q  <= 1'b0;
            rd_shift_q <= '0;
            rd_data_q  <= '0;
            mdio_o_q   <= 1'b1;
            mdio_oe_q  <= 1'b0;
            done_q     <= 1'b0;
            mdc_q      <= 1'b0;
`ifdef MDIO_TA_CHECK_EN
            ta_err_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            is_read_q  <= is_read_d;
            rd_shift_q <= rd_shift_d;
            rd_data_q  <= rd_data_d;
            mdio_o_q   <= mdio_o_d;
            mdio_oe_q  <= mdio_oe_d;
            done_q     <= done_d;
            mdc_q      <= mdc_in;
`ifdef MDIO_TA_CHECK_EN
            ta_err_q   <= ta_err_d;
`endif
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign rd_data   = rd_data_q;
    assign mdio_o    = mdio_o_q;
    assign mdio_oe   = mdio_oe_q;

`ifdef MDIO_TA_CHECK_EN
    assign ta_err = ta_err_q;
`else
    assign ta_err = 1'b0;
`endif

endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: self-checking bench for mdio_master. Two instances are
// used: one with the default 32-slot preamble, one with a 1-slot preamble.
// MDC is generated here, so every slot boundary is known by fall number and
// the pin values of each slot are logged just before the fall ending it.
module tb_mdio_master;

    localparam int P0 = 32;
    localparam int P1 = 1;
    localparam int LOG_DEPTH = 8192;
`ifdef MDIO_TA_CHECK_EN
    localparam bit TA_CHECK = 1'b1;
`else
    localparam bit TA_CHECK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mdc_in = 1'b0;
    logic        cmd_valid0 = 1'b0;
    logic        cmd_valid1 = 1'b0;
    logic        cmd_read = 1'b0;
    logic [4:0]  cmd_phy = '0;
    logic [4:0]  cmd_reg = '0;
    logic [15:0] cmd_wdata = '0;
    logic        mdio_i0 = 1'b1;
    logic        mdio_i1 = 1'b1;

    logic        cmd_ready0, done0, busy0, mdio_o0, mdio_oe0, ta_err0;
    logic        cmd_ready1, done1, busy1, mdio_o1, mdio_oe1, ta_err1;
    logic [15:0] rd_data0, rd_data1;

    mdio_master #(.PREAMBLE_LEN(P0), .SYNC_STAGES(2)) u_dut0 (
        .clk(clk), .rst(rst), .mdc_in(mdc_in),
        .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_read(cmd_read),
        .cmd_phy(cmd_phy), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
        .done(done0), .rd_data(rd_data0), .busy(busy0),
        .mdio_o(mdio_o0), .mdio_oe(mdio_oe0), .mdio_i(mdio_i0), .ta_err(ta_err0)
    );

    mdio_master #(.PREAMBLE_LEN(P1), .SYNC_STAGES(2)) u_dut1 (
        .clk(clk), .rst(rst), .mdc_in(mdc_in),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_read(cmd_read),
        .cmd_phy(cmd_phy), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
        .done(done1), .rd_data(rd_data1), .busy(busy1),
        .mdio_o(mdio_o1), .mdio_oe(mdio_oe1), .mdio_i(mdio_i1), .ta_err(ta_err1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle counter and done-pulse counters.
    int cyc = 0;
    int doneCnt0 = 0;
    int doneCnt1 = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (done0) doneCnt0 <= doneCnt0 + 1;
        if (done1) doneCnt1 <= doneCnt1 + 1;
    end

    // MDC generator plus slot logger plus PHY response model.
    int  half = 4;
    int  fallCnt = 0;
    int  fallCyc = 0;
    bit  logO0[LOG_DEPTH];
    bit  logOe0[LOG_DEPTH];
    bit  logO1[LOG_DEPTH];
    bit  logOe1[LOG_DEPTH];
    bit          phyActive = 1'b0;
    int          phyStart = 0;
    logic [15:0] phyData = '0;
    bit          phyTaHigh = 1'b0;

    initial begin
        forever begin
            repeat (half) @(negedge clk);
            if (mdc_in) begin
                fallCnt = fallCnt + 1;
                if (fallCnt < LOG_DEPTH) begin
                    logO0[fallCnt]  = mdio_o0;
                    logOe0[fallCnt] = mdio_oe0;
                    logO1[fallCnt]  = mdio_o1;
                    logOe1[fallCnt] = mdio_oe1;
                end
                fallCyc = cyc;
                mdc_in = 1'b0;
            end else begin
                mdc_in = 1'b1;
                // PHY changes the line mid-slot, on the rising edge.
                if (phyActive) begin
                    int k;
                    k = fallCnt - phyStart;
                    if (k == P0 + 15) begin
                        mdio_i0 = phyTaHigh;
                    end else if (k >= P0 + 16 && k <= P0 + 31) begin
                        mdio_i0 = phyData[15 - (k - P0 - 16)];
                    end else begin
                        mdio_i0 = 1'b1;
                    end
                end else begin
                    mdio_i0 = 1'b1;
                end
            end
        end
    end

    function automatic logic selReady(input int i);
        return (i == 0) ? cmd_ready0 : cmd_ready1;
    endfunction
    function automatic logic selDone(input int i);
        return (i == 0) ? done0 : done1;
    endfunction
    function automatic logic selBusy(input int i);
        return (i == 0) ? busy0 : busy1;
    endfunction
    function automatic logic [15:0] selRd(input int i);
        return (i == 0) ? rd_data0 : rd_data1;
    endfunction

    typedef struct {
        int          inst;
        int          f0;
        int          p;
        bit          rd;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [15:0] wd;
    } frame_t;

    frame_t      frames[$];
    logic [15:0] expRd[2] = '{16'h0, 16'h0};
    int          expDone[2] = '{0, 0};
    int          lastNeed = 0;

    // Presents a command and returns the fall count at the accepting edge;
    // slot 0 of the frame starts at the next fall.
    task automatic startCommand(input int inst, input bit rd, input logic [4:0] phy,
                                input logic [4:0] rg, input logic [15:0] wd,
                                input logic [15:0] resp, input bit taHigh, output int f0);
        int n;
        @(negedge clk);
        cmd_read  = rd;
        cmd_phy   = phy;
        cmd_reg   = rg;
        cmd_wdata = wd;
        if (inst == 0) cmd_valid0 = 1'b1;
        else           cmd_valid1 = 1'b1;
        n = 0;
        while (!selReady(inst) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("accept_wait", 128'(n < 4000), 128'(1));
        @(posedge clk);
        #1;
        f0 = fallCnt;
        if (inst == 0 && rd) begin
            phyStart  = f0 + 1;
            phyData   = resp;
            phyTaHigh = taHigh;
            phyActive = 1'b1;
        end
        @(negedge clk);
        cmd_valid0 = 1'b0;
        cmd_valid1 = 1'b0;
    endtask

    task automatic waitDone(input int inst, input int f0, input int p, input bit rd,
                            input logic [15:0] expData);
        int n;
        bit seen, readySeen, busyLow;
        n = 0;
        seen = 1'b0;
        readySeen = 1'b0;
        busyLow = 1'b0;
        while (!seen && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
            if (selDone(inst)) begin
                seen = 1'b1;
            end else begin
                if (selReady(inst)) readySeen = 1'b1;
                if (!selBusy(inst)) busyLow = 1'b1;
            end
        end
        checkOutput("done_seen", 128'(seen), 128'(1));
        checkOutput("done_fall", 128'(fallCnt), 128'(f0 + p + 33));
        checkOutput("done_latency", 128'(cyc - fallCyc), 128'(1));
        checkOutput("busy_at_done", 128'(selBusy(inst)), 128'(0));
        checkOutput("ready_at_done", 128'(selReady(inst)), 128'(1));
        checkOutput("ready_in_frame", 128'(readySeen), 128'(0));
        checkOutput("busy_in_frame", 128'(busyLow), 128'(0));
        checkOutput(rd ? "rd_data" : "rd_data_hold", 128'(selRd(inst)), 128'(expData));
    endtask

    task automatic applyStimulus(input int inst, input bit rd, input logic [4:0] phy,
                                 input logic [4:0] rg, input logic [15:0] wd,
                                 input logic [15:0] resp, input bit taHigh);
        int f0, p;
        frame_t fr;
        p = (inst == 0) ? P0 : P1;
        startCommand(inst, rd, phy, rg, wd, resp, taHigh, f0);
        if (rd) expRd[inst] = resp;
        waitDone(inst, f0, p, rd, expRd[inst]);
        expDone[inst]++;
        fr.inst = inst;
        fr.f0   = f0;
        fr.p    = p;
        fr.rd   = rd;
        fr.phy  = phy;
        fr.rg   = rg;
        fr.wd   = wd;
        frames.push_back(fr);
        if (f0 + p + 35 > lastNeed) lastNeed = f0 + p + 35;
    endtask

    // Reference: slot k < P is preamble '1'; slots P..P+31 carry the frame
    // word MSB first, released from slot P+14 on reads; slot P+32 is idle.
    task automatic checkFrames();
        logic [127:0] eO, eOe, oO, oOe;
        logic [31:0]  word;
        int           n, idx;
        bit           expOe, expO, gotOe, gotO;
        foreach (frames[i]) begin
            eO = '0; eOe = '0; oO = '0; oOe = '0;
            word = {2'b01, (frames[i].rd ? 2'b10 : 2'b01), frames[i].phy, frames[i].rg,
                    2'b10, frames[i].wd};
            n = frames[i].p + 33;
            for (int k = 0; k < n; k++) begin
                idx = frames[i].f0 + k + 2;
                expOe = (k < frames[i].p + 32) && !(frames[i].rd && k >= frames[i].p + 14);
                if (k < frames[i].p)            expO = 1'b1;
                else if (k < frames[i].p + 32)  expO = word[31 - (k - frames[i].p)];
                else                            expO = 1'b1;
                if (idx < LOG_DEPTH) begin
                    gotOe = (frames[i].inst == 0) ? logOe0[idx] : logOe1[idx];
                    gotO  = (frames[i].inst == 0) ? logO0[idx]  : logO1[idx];
                end else begin
                    gotOe = ~expOe;
                    gotO  = ~expO;
                end
                eOe[k] = expOe;
                oOe[k] = gotOe;
                if (expOe) begin
                    eO[k] = expO;
                    oO[k] = gotO;
                end
            end
            checkOutput($sformatf("slot_oe_frame%0d", i), oOe, eOe);
            checkOutput($sformatf("slot_o_frame%0d", i), oO, eO);
        end
    endtask

    initial begin
        int f0, n, doneBefore;
        logic [15:0] resp;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_ready", 128'(cmd_ready0), 128'(1));
        checkOutput("rst_busy", 128'(busy0), 128'(0));
        checkOutput("rst_done", 128'(done0), 128'(0));
        checkOutput("rst_oe", 128'(mdio_oe0), 128'(0));
        checkOutput("rst_o", 128'(mdio_o0), 128'(1));
        checkOutput("rst_rd_data", 128'(rd_data0), 128'(0));
        checkOutput("rst_ta_err", 128'(ta_err0), 128'(0));
        checkOutput("rst_ready1", 128'(cmd_ready1), 128'(1));

        // Directed write, directed read, then a back-to-back write.
        half = 4;
        applyStimulus(0, 1'b0, 5'h01, 5'h00, 16'h1140, 16'h0000, 1'b0);
        applyStimulus(0, 1'b1, 5'h03, 5'h02, 16'hDEAD, 16'h0141, 1'b0);
        checkOutput("ta_err_clean", 128'(ta_err0), 128'(0));
        applyStimulus(0, 1'b0, 5'h1F, 5'h1A, 16'hA5C3, 16'h0000, 1'b0);

        // Randomized traffic with varying MDC rate and gaps.
        for (int i = 0; i < 8; i++) begin
            half = $urandom_range(4, 7);
            repeat ($urandom_range(0, 15)) @(negedge clk);
            applyStimulus(0, 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom),
                          16'($urandom), 16'($urandom), 1'b0);
        end

        // Single-slot preamble instance.
        half = 4;
        applyStimulus(1, 1'b0, 5'($urandom), 5'($urandom), 16'($urandom), 16'h0000, 1'b0);
        applyStimulus(1, 1'b0, 5'h15, 5'h0A, 16'h8001, 16'h0000, 1'b0);

        // Reset in the middle of a read frame.
        startCommand(0, 1'b1, 5'h07, 5'h11, 16'h0000, 16'hBEEF, 1'b0, f0);
        n = 0;
        while (fallCnt < f0 + 41 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("slot40_wait", 128'(n < 4000), 128'(1));
        doneBefore = doneCnt0;
        @(negedge clk);
        rst = 1'b1;
        phyActive = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst_oe", 128'(mdio_oe0), 128'(0));
        checkOutput("midrst_busy", 128'(busy0), 128'(0));
        checkOutput("midrst_rd_data", 128'(rd_data0), 128'(0));
        checkOutput("midrst_o", 128'(mdio_o0), 128'(1));
        @(negedge clk);
        rst = 1'b0;
        expRd[0] = 16'h0000;
        @(posedge clk);
        #1;
        checkOutput("midrst_ready", 128'(cmd_ready0), 128'(1));
        repeat (300) @(negedge clk);
        @(posedge clk);
        #1;
        checkOutput("midrst_no_done", 128'(doneCnt0 - doneBefore), 128'(0));
        checkOutput("midrst_oe_idle", 128'(mdio_oe0), 128'(0));

        resp = 16'($urandom);
        applyStimulus(0, 1'b1, 5'h07, 5'h11, 16'h0000, resp, 1'b0);

        // PHY fails to drive turnaround low.
        applyStimulus(0, 1'b1, 5'h02, 5'h05, 16'h0000, 16'h3C5A, 1'b1);
        checkOutput("ta_err_set", 128'(ta_err0), 128'(TA_CHECK));
        applyStimulus(0, 1'b1, 5'h02, 5'h06, 16'h0000, 16'($urandom), 1'b0);
        checkOutput("ta_err_hold", 128'(ta_err0), 128'(TA_CHECK));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expRd[0] = 16'h0000;
        @(posedge clk);
        #1;
        checkOutput("ta_err_cleared", 128'(ta_err0), 128'(0));
        checkOutput("rd_data_cleared", 128'(rd_data0), 128'(expRd[0]));

        // Let the slot logs cover the idle slot after the last frame.
        n = 0;
        while (fallCnt < lastNeed && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("log_wait", 128'(n < 4000), 128'(1));
        checkFrames();
        @(posedge clk);
        #1;
        checkOutput("done_count0", 128'(doneCnt0), 128'(expDone[0]));
        checkOutput("done_count1", 128'(doneCnt1), 128'(expDone[1]));
        checkOutput("ta_err1_clean", 128'(ta_err1), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
